// File: rtl/adc_axis_pkg.sv
// Shared field layout, beat payload and receiver state encoding for the ADC stream sink.
package adc_axis_pkg;

  localparam int unsigned CNT_MSB = 63;
  localparam int unsigned CNT_LSB = 32;
  localparam int unsigned I_MSB   = 31;
  localparam int unsigned I_LSB   = 16;
  localparam int unsigned Q_MSB   = 15;
  localparam int unsigned Q_LSB   = 0;

  localparam int unsigned BEAT_DW = 64;
  localparam int unsigned KEEP_W  = 8;
  localparam logic [KEEP_W-1:0] KEEP_ALL = 8'hFF;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    SYNC  = 2'd1,
    RUN   = 2'd2
  } rx_state_e;

  // Payload carried through the skid buffer
  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [BEAT_DW-1:0] data;
  } rx_beat_t;

  localparam int unsigned BEAT_W = $bits(rx_beat_t);

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry FIFO-style skid buffer; ready is registered and drops only when both entries are full.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             pop_i
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             ready_q;
  logic             push_c;

  assign push_c  = valid_i && ready_q;
  assign count_d = count_q + 2'(push_c) - 2'(pop_i);
  assign ready_o = ready_q;
  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];

  // Storage needs no reset; occupancy tracking does
  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers, occupancy and registered ready
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
    end
  end

endmodule

// File: rtl/adc_axis_frame_rx.sv
// ADC stream sink: unpacks I/Q, checks counter continuity/keep/framing, keeps statistics.
module adc_axis_frame_rx
  import adc_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter logic [15:0] CNT_SAT     = 16'hFFFF
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic [7:0]             s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                   rx_enable,
  input  logic                   stats_clear,
  output logic [15:0]            sample_i,
  output logic [15:0]            sample_q,
  output logic                   sample_last,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   gap_err,
  output logic                   keep_err,
  output logic [31:0]            frame_count,
  output logic [31:0]            last_frame_len,
  output logic [15:0]            gap_count,
  output logic [31:0]            drop_count
);

  rx_beat_t    in_beat, head;
  logic        head_valid;
  logic        pop_c, deliver_c, gap_c, keep_bad_c;
  logic [31:0] head_cnt;
  logic        unused_tuser;

  rx_state_e   state_q;
  logic [31:0] expected_q, len_q;
  logic [15:0] sample_i_q, sample_q_q;
  logic        sample_last_q, sample_valid_q, gap_err_q, keep_err_q;
  logic [31:0] frame_count_q, last_frame_len_q, drop_count_q;
  logic [15:0] gap_count_q;

  assign unused_tuser = ^s_axis_tuser;
  assign in_beat      = '{last: s_axis_tlast, keep: s_axis_tkeep, data: 64'(s_axis_tdata)};

  axis_skid_buffer #(.WIDTH(BEAT_W)) u_skid (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .data_i  (in_beat),
    .valid_i (s_axis_tvalid),
    .ready_o (s_axis_tready),
    .data_o  (head),
    .valid_o (head_valid),
    .pop_i   (pop_c)
  );

  assign head_cnt   = head.data[CNT_MSB:CNT_LSB];
  assign gap_c      = (state_q == RUN) && (head_cnt != expected_q);
  assign keep_bad_c = (head.keep != KEEP_ALL);
  assign deliver_c  = pop_c && (state_q != FLUSH);

  // Pop: drain-and-discard in FLUSH, otherwise move into the output register when it is free
  always_comb begin
    pop_c = 1'b0;
    if (state_q == FLUSH) begin
      pop_c = head_valid;
    end else if (rx_enable) begin
      pop_c = head_valid && (!sample_valid_q || sample_ready);
    end
  end

  // Framing FSM, output register, continuity checker and statistics
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q          <= FLUSH;
      expected_q       <= 32'd0;
      len_q            <= 32'd0;
      sample_i_q       <= 16'd0;
      sample_q_q       <= 16'd0;
      sample_last_q    <= 1'b0;
      sample_valid_q   <= 1'b0;
      gap_err_q        <= 1'b0;
      keep_err_q       <= 1'b0;
      frame_count_q    <= 32'd0;
      last_frame_len_q <= 32'd0;
      gap_count_q      <= 16'd0;
      drop_count_q     <= 32'd0;
    end else begin
      gap_err_q  <= deliver_c && gap_c;
      keep_err_q <= deliver_c && keep_bad_c;

      if (deliver_c) begin
        sample_i_q     <= head.data[I_MSB:I_LSB];
        sample_q_q     <= head.data[Q_MSB:Q_LSB];
        sample_last_q  <= head.last;
        sample_valid_q <= 1'b1;
      end else if (sample_ready) begin
        sample_valid_q <= 1'b0;
      end

      case (state_q)
        FLUSH: begin
          if (rx_enable && !head_valid) state_q <= SYNC;
        end
        SYNC, RUN: begin
          if (!rx_enable) begin
            state_q <= FLUSH;
            len_q   <= 32'd0;
          end else if (deliver_c) begin
            expected_q <= head_cnt + 32'd1;
            state_q    <= head.last ? SYNC : RUN;
            len_q      <= head.last ? 32'd0 : len_q + 32'd1;
          end
        end
        default: state_q <= FLUSH;
      endcase

      if (stats_clear) begin
        frame_count_q    <= 32'd0;
        last_frame_len_q <= 32'd0;
        gap_count_q      <= 16'd0;
        drop_count_q     <= 32'd0;
      end else begin
        if (deliver_c && head.last) begin
          frame_count_q    <= frame_count_q + 32'd1;
          last_frame_len_q <= len_q + 32'd1;
        end
        if (deliver_c && gap_c && (gap_count_q != CNT_SAT)) gap_count_q <= gap_count_q + 16'd1;
        if (pop_c && (state_q == FLUSH)) drop_count_q <= drop_count_q + 32'd1;
      end
    end
  end

  assign sample_i       = sample_i_q;
  assign sample_q       = sample_q_q;
  assign sample_last    = sample_last_q;
  assign sample_valid   = sample_valid_q;
  assign gap_err        = gap_err_q;
  assign keep_err       = keep_err_q;
  assign frame_count    = frame_count_q;
  assign last_frame_len = last_frame_len_q;
  assign gap_count      = gap_count_q;
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_adc_axis_frame_rx.sv
// Directed bench for adc_axis_frame_rx with a frame-level reference model and per-cycle output compare.
module tb_adc_axis_frame_rx;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [63:0] s_axis_tdata = 64'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  s_axis_tkeep = 8'hFF;
  logic [0:0]  s_axis_tuser = 1'b0;
  logic        rx_enable = 1'b1;
  logic        stats_clear = 1'b0;
  logic [15:0] sample_i, sample_q;
  logic        sample_last, sample_valid;
  logic        sample_ready = 1'b1;
  logic        gap_err, keep_err;
  logic [31:0] frame_count, last_frame_len, drop_count;
  logic [15:0] gap_count;

  adc_axis_frame_rx dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .rx_enable(rx_enable), .stats_clear(stats_clear),
    .sample_i(sample_i), .sample_q(sample_q), .sample_last(sample_last),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .gap_err(gap_err), .keep_err(keep_err),
    .frame_count(frame_count), .last_frame_len(last_frame_len),
    .gap_count(gap_count), .drop_count(drop_count)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: what the sink must emit for each accepted beat
  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
    logic        last;
    logic        gap;
    logic        keep;
  } exp_t;

  exp_t        expq[$];
  bit          m_en = 1'b1;
  bit          m_mid = 1'b0;
  logic [31:0] m_prev = 32'd0;
  int unsigned m_len = 0, m_frames = 0, m_last_len = 0, m_gaps = 0, m_drops = 0;

  task automatic model_beat(input logic [31:0] cnt, input logic [15:0] i, input logic [15:0] q,
                            input logic last, input logic [7:0] keep);
    exp_t e;
    if (!m_en) begin
      m_drops++;
      return;
    end
    e.i    = i;
    e.q    = q;
    e.last = last;
    e.keep = (keep != 8'hFF);
    e.gap  = m_mid && (cnt != m_prev + 32'd1);
    expq.push_back(e);
    m_prev = cnt;
    m_len++;
    if (e.gap && m_gaps < 32'hFFFF) m_gaps++;
    if (last) begin
      m_frames++;
      m_last_len = m_len;
      m_len = 0;
      m_mid = 1'b0;
    end else begin
      m_mid = 1'b1;
    end
  endtask

  // Downstream ready: held high, or pseudo-random while rand_mode is set
  bit rand_mode = 1'b0;
  always @(posedge aclk) begin
    #1;
    sample_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: compares every presented sample and every error strobe against the model
  bit   mon_on = 1'b0;
  bit   held_prev = 1'b0;
  exp_t m_e;
  int   first_valid_cyc = -1, first_acc_cyc = -1, last_hs_cyc = 0;
  int   hs_count = 0, gap_seen = 0, keep_seen = 0;

  always @(negedge aclk) begin
    if (mon_on) begin
      if (sample_valid && !held_prev) begin
        if (expq.size() == 0) begin
          chk("unexpected_sample", 64'd1, 64'd0);
        end else begin
          m_e = expq[0];
          chk("gap_err", 64'(gap_err), 64'(m_e.gap));
          chk("keep_err", 64'(keep_err), 64'(m_e.keep));
        end
        if (gap_err) gap_seen++;
        if (keep_err) keep_seen++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end else begin
        chk("err_strobe_idle", 64'({gap_err, keep_err}), 64'd0);
      end
      if (sample_valid && sample_ready && expq.size() != 0) begin
        m_e = expq.pop_front();
        chk("sample_iq", 64'({sample_i, sample_q}), 64'({m_e.i, m_e.q}));
        chk("sample_last", 64'(sample_last), 64'(m_e.last));
        hs_count++;
        last_hs_cyc = cyc;
      end
      held_prev = sample_valid && !sample_ready;
    end
  end

  // Drive one beat from a negedge; returns at the negedge after it was accepted
  task automatic send(input logic [31:0] cnt, input logic [15:0] i, input logic [15:0] q,
                      input logic last, input logic [7:0] keep);
    int   n;
    logic acc;
    s_axis_tdata  = {cnt, i, q};
    s_axis_tlast  = last;
    s_axis_tkeep  = keep;
    s_axis_tvalid = 1'b1;
    n = 0;
    do begin
      acc = s_axis_tready;
      @(negedge aclk);
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    else begin
      model_beat(cnt, i, q, last, keep);
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
    end
  endtask

  task automatic send_frame(input logic [31:0] c0, input int n);
    for (int k = 0; k < n; k++)
      send(c0 + 32'(k), 16'(16'h1000 + k), 16'(16'h2000 + 3 * k), k == n - 1, 8'hFF);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || sample_valid) && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 64'(expq.size()), 64'd0);
    repeat (3) @(negedge aclk);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_frame_count"}, 64'(frame_count), 64'(m_frames));
    chk({tag, "_last_frame_len"}, 64'(last_frame_len), 64'(m_last_len));
    chk({tag, "_gap_count"}, 64'(gap_count), 64'(m_gaps));
    chk({tag, "_drop_count"}, 64'(drop_count), 64'(m_drops));
  endtask

  initial begin
    #1 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_valid", 64'(sample_valid), 64'd0);
    chk("rst_errs", 64'({gap_err, keep_err}), 64'd0);
    chk("rst_stats", {frame_count, last_frame_len}, 64'd0);
    chk("rst_stats2", {16'd0, gap_count, drop_count}, 64'd0);
    aresetn = 1'b1;
    mon_on  = 1'b1;

    // Frame 100..107: latency, throughput and first statistics
    send_frame(32'd100, 8);
    drain();
    chk("t1_latency", 64'(first_valid_cyc - first_acc_cyc), 64'd1);
    chk("t1_samples", 64'(hs_count), 64'd8);
    chk("t1_back_to_back", 64'(last_hs_cyc - first_valid_cyc), 64'd7);
    chk("t1_frame_count_lit", 64'(frame_count), 64'd1);
    chk("t1_len_lit", 64'(last_frame_len), 64'd8);
    chk("t1_gap_lit", 64'(gap_count), 64'd0);
    check_stats("t1");

    // 5, 6, 9, 10: one discontinuity on 9
    send(32'd5, 16'h0005, 16'hFFF5, 1'b0, 8'hFF);
    send(32'd6, 16'h0006, 16'hFFF6, 1'b0, 8'hFF);
    send(32'd9, 16'h0009, 16'hFFF9, 1'b0, 8'hFF);
    send(32'd10, 16'h000A, 16'hFFFA, 1'b1, 8'hFF);
    s_axis_tvalid = 1'b0;
    drain();
    chk("t2_gap_count_lit", 64'(gap_count), 64'd1);
    chk("t2_gap_pulses_lit", 64'(gap_seen), 64'd1);
    chk("t2_len_lit", 64'(last_frame_len), 64'd4);
    check_stats("t2");

    // Counter wrap is continuous
    send(32'hFFFF_FFFE, 16'h0A0A, 16'h0B0B, 1'b0, 8'hFF);
    send(32'hFFFF_FFFF, 16'h0C0C, 16'h0D0D, 1'b0, 8'hFF);
    send(32'h0000_0000, 16'h0E0E, 16'h0F0F, 1'b0, 8'hFF);
    send(32'h0000_0001, 16'h1111, 16'h2222, 1'b1, 8'hFF);
    s_axis_tvalid = 1'b0;
    drain();
    chk("t3_gap_count_lit", 64'(gap_count), 64'd1);
    check_stats("t3");

    // 64-beat frame under random backpressure
    hs_count  = 0;
    rand_mode = 1'b1;
    send_frame(32'd1000, 64);
    drain();
    rand_mode = 1'b0;
    drain();
    chk("t4_samples", 64'(hs_count), 64'd64);
    chk("t4_frame_count_lit", 64'(frame_count), 64'd4);
    check_stats("t4");

    // Flush: beats are accepted and discarded
    rx_enable = 1'b0;
    m_en  = 1'b0;
    m_mid = 1'b0;
    m_len = 0;
    repeat (2) @(negedge aclk);
    for (int k = 0; k < 10; k++) begin
      s_axis_tdata  = {32'(7 * k + 3), 16'h5555, 16'hAAAA};
      s_axis_tlast  = (k == 9);
      s_axis_tkeep  = 8'hFF;
      s_axis_tvalid = 1'b1;
      chk("flush_tready", 64'(s_axis_tready), 64'd1);
      chk("flush_valid", 64'(sample_valid), 64'd0);
      @(negedge aclk);
      model_beat(32'(7 * k + 3), 16'h5555, 16'hAAAA, k == 9, 8'hFF);
    end
    s_axis_tvalid = 1'b0;
    repeat (3) @(negedge aclk);
    chk("t5_drop_lit", 64'(drop_count), 64'd10);
    chk("t5_valid_after", 64'(sample_valid), 64'd0);
    rx_enable = 1'b1;
    m_en = 1'b1;
    repeat (2) @(negedge aclk);
    send(32'hDEAD_0000, 16'h1234, 16'h5678, 1'b0, 8'hFF);
    send(32'hDEAD_0001, 16'h9ABC, 16'hDEF0, 1'b1, 8'hFF);
    s_axis_tvalid = 1'b0;
    drain();
    chk("t5_gap_pulses_lit", 64'(gap_seen), 64'd1);
    check_stats("t5");

    // Bad keep, then statistics clear over the tlast delivery
    send(32'd7000, 16'h7000, 16'h0007, 1'b0, 8'h0F);
    send(32'd7001, 16'h7001, 16'h0107, 1'b1, 8'hFF);
    s_axis_tvalid = 1'b0;
    stats_clear   = 1'b1;
    m_frames = 0; m_last_len = 0; m_gaps = 0; m_drops = 0;
    repeat (3) @(negedge aclk);
    stats_clear = 1'b0;
    drain();
    chk("t6_keep_pulses_lit", 64'(keep_seen), 64'd1);
    chk("t6_frame_count_lit", 64'(frame_count), 64'd0);
    check_stats("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
